// File: rtl/irq_scheduler.sv
// irq_scheduler
//   Latches rising edges on NSRC interrupt request lines and pushes each one into an
//   external FIFO as a vector. The FIFO is edge-triggered with slow flags, so each push
//   and pop waits for its flags to settle. Popped vectors are presented to the CPU one
//   at a time and held until the CPU acknowledges.
//
// Ports
//   clock, reset          system clock; asynchronous active-high reset
//   irq_req[NSRC]         level request lines (synchronous to clock)
//   irq_mask[NSRC]        1 = rising edges on that source are ignored
//   fifo_full/empty/dout  FIFO status and read data
//   fifo_wr, fifo_rd      single-cycle FIFO strobes
//   fifo_din              push data (source index), stable across a whole push sequence
//   cpu_irq, cpu_vector   vector presented to the CPU
//   cpu_ack               one-cycle CPU acknowledge
//   overflow              sticky: an edge arrived on a source that was already pending
module irq_scheduler #(
    parameter int NSRC  = 8,
    parameter int DBITS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NSRC-1:0]  irq_req,
    input  logic [NSRC-1:0]  irq_mask,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_dout,
    output logic             fifo_wr,
    output logic             fifo_rd,
    output logic [DBITS-1:0] fifo_din,
    output logic             cpu_irq,
    output logic [DBITS-1:0] cpu_vector,
    input  logic             cpu_ack,
    output logic             overflow
);

    localparam int IW = $clog2(NSRC);

    typedef enum logic [1:0] {P_IDLE, P_WR, P_HOLD} push_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RD, R_WAIT, R_PRES} pop_state_t;

    // ---------------------------------------------------------------- capture
    logic [NSRC-1:0] req_hist_reg;
    logic [NSRC-1:0] pending_reg, pending_next;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] grant_clear;
    logic            overflow_reg;

    assign rise = irq_req & ~req_hist_reg & ~irq_mask;

    // A new edge in the same cycle as the grant of that source keeps it pending.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pending
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~grant_clear[gi]);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_hist_reg <= '0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            req_hist_reg <= irq_req;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_reg | (|(rise & pending_reg));
        end
    end

    assign overflow = overflow_reg;

    // --------------------------------------------------- round-robin grant
    logic [IW-1:0] rr_reg, rr_next;
    logic [IW-1:0] grant_idx;
    logic          grant_found;

    // Scan from the rr pointer upward, wrapping at NSRC, and take the first pending source.
    always_comb begin
        logic [IW:0] probe;
        grant_idx   = '0;
        grant_found = 1'b0;
        probe       = '0;
        for (int k = 0; k < NSRC; k++) begin
            probe = {1'b0, rr_reg} + (IW+1)'(k);
            if (probe >= (IW+1)'(NSRC)) begin
                probe = probe - (IW+1)'(NSRC);
            end
            if (!grant_found && pending_reg[probe[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = probe[IW-1:0];
            end
        end
    end

    // ---------------------------------------------------------------- push FSM
    push_state_t      push_state_reg, push_state_next;
    logic [1:0]       hold_cnt_reg, hold_cnt_next;
    logic [DBITS-1:0] din_reg, din_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            push_state_reg <= P_IDLE;
            hold_cnt_reg   <= '0;
            din_reg        <= '0;
            rr_reg         <= '0;
        end else begin
            push_state_reg <= push_state_next;
            hold_cnt_reg   <= hold_cnt_next;
            din_reg        <= din_next;
            rr_reg         <= rr_next;
        end
    end

    // P_HOLD lasts three cycles so fifo_full reflects this push before the next grant.
    always_comb begin
        push_state_next = push_state_reg;
        hold_cnt_next   = hold_cnt_reg;
        din_next        = din_reg;
        rr_next         = rr_reg;
        grant_clear     = '0;
        fifo_wr         = 1'b0;
        unique case (push_state_reg)
            P_IDLE: begin
                if (grant_found && !fifo_full) begin
                    din_next               = DBITS'(grant_idx);
                    grant_clear[grant_idx] = 1'b1;
                    rr_next                = (grant_idx == IW'(NSRC - 1)) ? '0 : grant_idx + 1'b1;
                    push_state_next        = P_WR;
                end
            end
            P_WR: begin
                fifo_wr         = 1'b1;
                hold_cnt_next   = '0;
                push_state_next = P_HOLD;
            end
            P_HOLD: begin
                if (hold_cnt_reg == 2'd2) begin
                    push_state_next = P_IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 2'd1;
                end
            end
            default: push_state_next = P_IDLE;
        endcase
    end

    assign fifo_din = din_reg;

    // ----------------------------------------------------------------- pop FSM
    pop_state_t       pop_state_reg, pop_state_next;
    logic [1:0]       wait_cnt_reg, wait_cnt_next;
    logic [DBITS-1:0] vec_reg, vec_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pop_state_reg <= R_IDLE;
            wait_cnt_reg  <= '0;
            vec_reg       <= '0;
        end else begin
            pop_state_reg <= pop_state_next;
            wait_cnt_reg  <= wait_cnt_next;
            vec_reg       <= vec_next;
        end
    end

    // fifo_dout is only valid three edges after the read strobe, so it is latched on
    // the final R_WAIT cycle.
    always_comb begin
        pop_state_next = pop_state_reg;
        wait_cnt_next  = wait_cnt_reg;
        vec_next       = vec_reg;
        fifo_rd        = 1'b0;
        cpu_irq        = 1'b0;
        unique case (pop_state_reg)
            R_IDLE: begin
                if (!fifo_empty) begin
                    pop_state_next = R_RD;
                end
            end
            R_RD: begin
                fifo_rd        = 1'b1;
                wait_cnt_next  = '0;
                pop_state_next = R_WAIT;
            end
            R_WAIT: begin
                if (wait_cnt_reg == 2'd2) begin
                    vec_next       = fifo_dout;
                    pop_state_next = R_PRES;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end
            R_PRES: begin
                cpu_irq = 1'b1;
                if (cpu_ack) begin
                    pop_state_next = R_IDLE;
                end
            end
            default: pop_state_next = R_IDLE;
        endcase
    end

    assign cpu_vector = vec_reg;

endmodule

// File: tb/tb_irq_scheduler.sv
// tb_irq_scheduler
//   Drives directed interrupt patterns into irq_scheduler, models the edge-triggered
//   irq_fifo (depth 4, flags/data settle three edges after a strobe) and a CPU that
//   acknowledges on demand. Expected push words and CPU vectors are queued when the
//   stimulus is issued; a monitor pops and compares them as the DUT produces them.
module tb_irq_scheduler;

    localparam int NSRC  = 8;
    localparam int DBITS = 32;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [NSRC-1:0]  irq_req;
    logic [NSRC-1:0]  irq_mask;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DBITS-1:0] fifo_dout;
    logic             fifo_wr;
    logic             fifo_rd;
    logic [DBITS-1:0] fifo_din;
    logic             cpu_irq;
    logic [DBITS-1:0] cpu_vector;
    logic             cpu_ack;
    logic             overflow;

    irq_scheduler #(.NSRC(NSRC), .DBITS(DBITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_req    (irq_req),
        .irq_mask   (irq_mask),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .fifo_din   (fifo_din),
        .cpu_irq    (cpu_irq),
        .cpu_vector (cpu_vector),
        .cpu_ack    (cpu_ack),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int last_wr_cyc  = -1;
    int last_irq_cyc = -1;
    bit auto_ack = 1'b1;

    logic [DBITS-1:0] exp_push[$];
    logic [DBITS-1:0] exp_cpu[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // ------------------------------------------------------------ FIFO model
    logic [DBITS-1:0] fq[$];
    logic             wr_d1, wr_d2, rd_d1, rd_d2;
    logic [DBITS-1:0] din_d1, din_d2;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fq.delete();
            wr_d1 <= 1'b0; wr_d2 <= 1'b0; rd_d1 <= 1'b0; rd_d2 <= 1'b0;
            din_d1 <= '0; din_d2 <= '0;
            fifo_full <= 1'b0; fifo_empty <= 1'b1; fifo_dout <= '0;
        end else begin
            wr_d1 <= fifo_wr;  wr_d2 <= wr_d1;
            din_d1 <= fifo_din; din_d2 <= din_d1;
            rd_d1 <= fifo_rd;  rd_d2 <= rd_d1;
            if (rd_d2 && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (wr_d2 && fq.size() < DEPTH) fq.push_back(din_d2);
            fifo_full  <= (fq.size() >= DEPTH);
            fifo_empty <= (fq.size() == 0);
        end
    end

    // ------------------------------------------------------------- CPU model
    initial begin
        forever begin
            @(negedge clock);
            cpu_ack = auto_ack && cpu_irq && !cpu_ack && !reset;
        end
    end

    // --------------------------------------------------------------- monitor
    initial begin
        logic             irq_prev;
        logic [DBITS-1:0] e;
        irq_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                irq_prev = 1'b0;
            end else begin
                if (fifo_wr) begin
                    n_wr++;
                    last_wr_cyc = cyc;
                    if (exp_push.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_push: got din=%0d, want no push", fifo_din);
                    end else begin
                        e = exp_push.pop_front();
                        $display("push   din=%0d cyc=%0d", fifo_din, cyc);
                        check("push_din", fifo_din, e);
                    end
                end
                if (cpu_irq && !irq_prev) begin
                    last_irq_cyc = cyc;
                    if (exp_cpu.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_irq: got vector=%0d, want no irq", cpu_vector);
                    end else begin
                        e = exp_cpu.pop_front();
                        $display("cpu    vector=%0d cyc=%0d", cpu_vector, cyc);
                        check("cpu_vector", cpu_vector, e);
                    end
                end
                irq_prev = cpu_irq;
            end
        end
    end

    // ------------------------------------------------------- stimulus helpers
    task automatic expect_vec(input int v);
        exp_push.push_back(DBITS'(v));
        exp_cpu.push_back(DBITS'(v));
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        @(negedge clock);
        irq_req = irq_req | m;
        @(negedge clock);
        irq_req = irq_req & ~m;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        exp_push.delete();
        exp_cpu.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (exp_push.size() == 0 && exp_cpu.size() == 0 && !cpu_irq && fifo_empty) begin
                done = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d pushes/%0d vectors outstanding, want 0/0",
                     name, exp_push.size(), exp_cpu.size());
        end
        repeat (3) @(negedge clock);
    endtask

    // Lone edge on source 3 into an empty FIFO; checks the minimum latency path.
    task automatic single_edge3(input string name);
        int  n0;
        bit  seen;
        expect_vec(3);
        @(negedge clock);
        n0 = cyc + 1;
        irq_req[3] = 1'b1;
        @(negedge clock);
        irq_req[3] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (cpu_irq) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check({name, "_irq_seen"}, 32'(seen), 32'd1);
        check({name, "_wr_latency"}, 32'(last_wr_cyc - n0), 32'd1);
        check({name, "_irq_latency"}, 32'(last_irq_cyc - n0), 32'd9);
        @(posedge clock);
        #1;
        check({name, "_irq_after_ack"}, 32'(cpu_irq), 32'd0);
        check({name, "_fifo_empty"}, 32'(fifo_empty), 32'd1);
        wait_drain(name, 40);
    endtask

    // -------------------------------------------------------------- watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------- scenarios
    initial begin
        int n0;
        int w0;
        reset    = 1'b1;
        irq_req  = '0;
        irq_mask = '0;
        cpu_ack  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_fifo_din", fifo_din, 32'd0);
        check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
        check("rst_cpu_vector", cpu_vector, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single edge, minimum latency.
        single_edge3("s1");

        // Simultaneous edges from rr=0, then wrap from rr=7, then ordering from rr=1.
        do_reset();
        expect_vec(1); expect_vec(5); expect_vec(6);
        pulse(8'b0110_0010);
        repeat (25) @(negedge clock);
        expect_vec(0);
        pulse(8'b0000_0001);
        repeat (10) @(negedge clock);
        expect_vec(2); expect_vec(7);
        pulse(8'b1000_0100);
        wait_drain("s2", 200);

        // Masked edge is ignored; unmasking without a new edge does nothing.
        w0 = n_wr;
        irq_mask = 8'b0000_0100;
        @(negedge clock);
        irq_req[2] = 1'b1;
        repeat (12) @(negedge clock);
        check("s3_masked_irq", 32'(cpu_irq), 32'd0);
        check("s3_masked_push", 32'(n_wr - w0), 32'd0);
        irq_mask = '0;
        repeat (20) @(negedge clock);
        check("s3_unmask_irq", 32'(cpu_irq), 32'd0);
        check("s3_unmask_push", 32'(n_wr - w0), 32'd0);
        irq_req[2] = 1'b0;
        repeat (3) @(negedge clock);

        // Backpressure: CPU holds vector 0, FIFO fills with 1,2,3,5.
        do_reset();
        auto_ack = 1'b0;
        expect_vec(0); expect_vec(1); expect_vec(2); expect_vec(3); expect_vec(5);
        pulse(8'b0010_1111);
        repeat (40) @(negedge clock);
        check("s4_fifo_full", 32'(fifo_full), 32'd1);
        check("s4_cpu_holding", 32'(cpu_irq), 32'd1);
        w0 = n_wr;
        pulse(8'b0001_0000);
        repeat (10) @(negedge clock);
        check("s4_no_push_full", 32'(n_wr - w0), 32'd0);
        check("s4_no_overflow_yet", 32'(overflow), 32'd0);
        pulse(8'b0001_0000);
        repeat (3) @(negedge clock);
        check("s4_overflow", 32'(overflow), 32'd1);
        check("s4_still_no_push", 32'(n_wr - w0), 32'd0);
        expect_vec(4);
        auto_ack = 1'b1;
        wait_drain("s4", 300);
        check("s4_overflow_sticky", 32'(overflow), 32'd1);
        check("s4_push_total", 32'(n_wr - w0), 32'd1);

        // Reset while push is in P_HOLD and pop is in R_WAIT (rr=5: grants 1 then 2).
        exp_push.push_back(1);
        exp_push.push_back(2);
        @(negedge clock);
        n0 = cyc + 1;
        irq_req = 8'b0000_0110;
        @(negedge clock);
        irq_req = '0;
        while (cyc < n0 + 7) @(negedge clock);
        check("s5_din_before", fifo_din, 32'd2);
        check("s5_ovf_before", 32'(overflow), 32'd1);
        check("s5_pushes_before", 32'(exp_push.size()), 32'd0);
        reset = 1'b1;
        #1;
        check("s5_rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check("s5_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("s5_rst_fifo_din", fifo_din, 32'd0);
        check("s5_rst_cpu_irq", 32'(cpu_irq), 32'd0);
        check("s5_rst_cpu_vector", cpu_vector, 32'd0);
        check("s5_rst_overflow", 32'(overflow), 32'd0);
        check("s5_rst_fifo_empty", 32'(fifo_empty), 32'd1);
        exp_push.delete();
        exp_cpu.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        w0 = n_wr;
        repeat (20) @(negedge clock);
        check("s5_idle_push", 32'(n_wr - w0), 32'd0);
        check("s5_idle_irq", 32'(cpu_irq), 32'd0);
        single_edge3("s5");

        // All sources, three rounds; rr=4 after the last grant of 3.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NSRC; k++) expect_vec((4 + k) % NSRC);
            pulse(8'hFF);
            repeat (78) @(negedge clock);
        end
        wait_drain("s6", 400);
        check("s6_overflow", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
